svm_load_sequencer: RTL
=======================

SVM_LOAD_SEQUENCER -- requirements
Module: svm_load_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, memory word address width.
REQ-002 Parameter TIMEOUT_CYCLES, default 256, maximum cycles spent in any WAIT state.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  job request, sampled in IDLE only.
REQ-006 num_dim  input  6  vector dimension, legal range 1..32.
REQ-007 weight_base  input  ADDR_WIDTH  address of weight element 0.
REQ-008 data_base  input  ADDR_WIDTH  address of data element 0.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when a job completes.
REQ-011 err  output  1  one-cycle pulse on illegal num_dim or timeout.
REQ-012 mem_rd_req  output  1  read request to the memory manager.
REQ-013 mem_rd_addr  output  ADDR_WIDTH  read address, valid while mem_rd_req is high.
REQ-014 mem_rd_gnt  input  1  request accepted this cycle.
REQ-015 clear_weights_n_data  output  1  clear pulse to the weight/data register array.
REQ-016 loading_weights  output  1  routes returning data into the weight registers.
REQ-017 loading_data  output  1  routes returning data into the data vector registers.
REQ-018 svm_ctrl_part_num_dim  output  6  latched num_dim, driven to the register array.
REQ-019 weights_progd  input  1  register array has received num_dim weights.
REQ-020 data_vec_progd  input  1  register array has received num_dim data words.
REQ-021 compute_start  output  1  one-cycle pulse that launches the dot-product.
REQ-022 compute_done  input  1  dot-product finished.

Function
REQ-023 The FSM SHALL have the states IDLE, CLEAR, REQ_W, WAIT_W, REQ_D, WAIT_D, COMPUTE and DONE.
REQ-024 IDLE: when start=1 and num_dim is in 1..32, the block SHALL latch num_dim, weight_base and data_base and go to CLEAR.
REQ-025 IDLE: when start=1 and num_dim is 0 or greater than 32, the block SHALL pulse err for one cycle, stay in IDLE and issue no requests.
REQ-026 start SHALL be ignored in every state other than IDLE.
REQ-027 CLEAR: clear_weights_n_data SHALL be high for exactly this one cycle; the next state is REQ_W and req_cnt is set to 0.
REQ-028 REQ_W: mem_rd_req=1 and mem_rd_addr=weight_base+req_cnt (truncated to ADDR_WIDTH).
  - mem_rd_gnt=1: req_cnt increments.
  - Grant with req_cnt=num_dim-1: next state is WAIT_W.
  - mem_rd_gnt=0: request and address are held unchanged.
REQ-029 WAIT_W: mem_rd_req=0; when weights_progd=1, the next state is REQ_D with req_cnt=0.
REQ-030 REQ_D and WAIT_D SHALL mirror REQ-028 and REQ-029, using data_base and data_vec_progd; WAIT_D exits to COMPUTE.
REQ-031 loading_weights SHALL be high exactly in REQ_W and WAIT_W.
REQ-032 loading_data SHALL be high exactly in REQ_D and WAIT_D.
REQ-033 loading_weights and loading_data SHALL never both be high.
REQ-034 COMPUTE: compute_start SHALL pulse in the first COMPUTE cycle only; when compute_done=1, the next state is DONE.
REQ-035 DONE: done SHALL pulse for one cycle, then the FSM returns to IDLE; start may be accepted in the following IDLE cycle.
REQ-036 Exactly num_dim granted requests SHALL be issued per phase; no request is issued outside REQ_W and REQ_D.
REQ-037 A wait counter SHALL clear on entry to WAIT_W, WAIT_D and COMPUTE, and increment each cycle in those states.
REQ-038 If the wait counter reaches TIMEOUT_CYCLES-1 without the exit condition, the block SHALL in the next cycle:
  - pulse err;
  - pulse clear_weights_n_data;
  - return to IDLE without pulsing done.
REQ-039 svm_ctrl_part_num_dim SHALL hold the latched value until the next accepted start.

Reset
REQ-040 On rst_n=0 at a clock edge, the FSM SHALL go to IDLE and the counters SHALL clear.
REQ-041 On reset, every output SHALL be 0, including svm_ctrl_part_num_dim and mem_rd_addr.
REQ-042 Reset SHALL take priority in every state, including mid-request; an in-flight grant is discarded.

Verification
REQ-043 Nominal job: num_dim=4, weight_base=0x0100, data_base=0x0200, gnt always 1, array modelled with 2-cycle return latency -> addresses 0x0100..0x0103 then 0x0200..0x0203; one clear pulse; one compute_start; one done.
REQ-044 Illegal dimension: start with num_dim=0, then with num_dim=33 -> err pulses once per start; busy and mem_rd_req stay 0.
REQ-045 Grant stall: num_dim=3, gnt=0 for 3 cycles on the second weight request -> mem_rd_addr held at weight_base+1 with req=1; exactly 3 weight grants.
REQ-046 Start while busy: start asserted during REQ_D -> no effect; the job completes with the original parameters.
REQ-047 Timeout: weights_progd never rises -> err and clear pulse 256 cycles after entering WAIT_W; FSM returns to IDLE; done stays 0.
REQ-048 Mid-operation reset: rst_n=0 during REQ_D -> all outputs 0 on the next cycle; a fresh num_dim=1 job afterwards completes normally.

Source files
------------

// File: rtl/svm_load_sequencer_if.sv
// Handshake and bus bundle between the SVM load sequencer, the memory
// manager, the weight/data register array and the dot-product engine.
interface svm_load_sequencer_if #(
   parameter int unsigned ADDR_WIDTH = 16
);
   // job control
   logic                  start;
   logic [5:0]            num_dim;
   logic [ADDR_WIDTH-1:0] weight_base;
   logic [ADDR_WIDTH-1:0] data_base;
   logic                  busy;
   logic                  done;
   logic                  err;
   // memory manager read port
   logic                  mem_rd_req;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   logic                  mem_rd_gnt;
   // register array control
   logic                  clear_weights_n_data;
   logic                  loading_weights;
   logic                  loading_data;
   logic [5:0]            svm_ctrl_part_num_dim;
   logic                  weights_progd;
   logic                  data_vec_progd;
   // dot-product engine
   logic                  compute_start;
   logic                  compute_done;

   // sequencer side
   modport master (
      input  start, num_dim, weight_base, data_base,
      input  mem_rd_gnt, weights_progd, data_vec_progd, compute_done,
      output busy, done, err,
      output mem_rd_req, mem_rd_addr,
      output clear_weights_n_data, loading_weights, loading_data,
      output svm_ctrl_part_num_dim, compute_start
   );

   // environment side (job source, memory manager, array, engine)
   modport slave (
      output start, num_dim, weight_base, data_base,
      output mem_rd_gnt, weights_progd, data_vec_progd, compute_done,
      input  busy, done, err,
      input  mem_rd_req, mem_rd_addr,
      input  clear_weights_n_data, loading_weights, loading_data,
      input  svm_ctrl_part_num_dim, compute_start
   );
endinterface

// File: rtl/svm_load_sequencer.sv
// SVM load sequencer: clears the register array, fetches num_dim weights
// then num_dim data words through the memory manager, launches the
// dot-product and reports done, or err on a bad dimension or a stuck wait.
module svm_load_sequencer #(
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input logic                 clk,
   input logic                 rst_n,
   svm_load_sequencer_if.master bus
);

   localparam int unsigned DIM_W  = 6;
   localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [DIM_W-1:0]  MAX_DIM   = DIM_W'(32);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_REQ_W, S_WAIT_W, S_REQ_D, S_WAIT_D, S_COMPUTE, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [DIM_W-1:0]      req_cnt_q, req_cnt_d;
   logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
   logic [DIM_W-1:0]      num_dim_q, num_dim_d;
   logic [ADDR_WIDTH-1:0] wbase_q, wbase_d;
   logic [ADDR_WIDTH-1:0] dbase_q, dbase_d;

   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  req_q, req_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  clear_q, clear_d;
   logic                  lw_q, lw_d;
   logic                  ld_q, ld_d;
   logic                  cstart_q, cstart_d;

   logic                  timeout_c;
   logic [DIM_W-1:0]      last_idx_c;

   // Next-state, counters and next values of every registered output
   always_comb begin
      state_d    = state_q;
      req_cnt_d  = req_cnt_q;
      wait_cnt_d = wait_cnt_q;
      num_dim_d  = num_dim_q;
      wbase_d    = wbase_q;
      dbase_d    = dbase_q;
      err_d      = 1'b0;
      clear_d    = 1'b0;
      cstart_d   = 1'b0;
      addr_d     = addr_q;
      timeout_c  = (wait_cnt_q == WAIT_LAST);
      last_idx_c = num_dim_q - DIM_W'(1);

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if ((bus.num_dim != '0) && (bus.num_dim <= MAX_DIM)) begin
                  num_dim_d = bus.num_dim;
                  wbase_d   = bus.weight_base;
                  dbase_d   = bus.data_base;
                  state_d   = S_CLEAR;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            state_d   = S_REQ_W;
            req_cnt_d = '0;
         end
         S_REQ_W: begin
            if (bus.mem_rd_gnt) begin
               if (req_cnt_q == last_idx_c) begin
                  state_d    = S_WAIT_W;
                  req_cnt_d  = '0;
                  wait_cnt_d = '0;
               end else begin
                  req_cnt_d = req_cnt_q + DIM_W'(1);
               end
            end
         end
         S_WAIT_W: begin
            if (bus.weights_progd) begin
               state_d   = S_REQ_D;
               req_cnt_d = '0;
            end else if (timeout_c) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               clear_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         S_REQ_D: begin
            if (bus.mem_rd_gnt) begin
               if (req_cnt_q == last_idx_c) begin
                  state_d    = S_WAIT_D;
                  req_cnt_d  = '0;
                  wait_cnt_d = '0;
               end else begin
                  req_cnt_d = req_cnt_q + DIM_W'(1);
               end
            end
         end
         S_WAIT_D: begin
            if (bus.data_vec_progd) begin
               state_d    = S_COMPUTE;
               wait_cnt_d = '0;
               cstart_d   = 1'b1;
            end else if (timeout_c) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               clear_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         S_COMPUTE: begin
            if (bus.compute_done) begin
               state_d = S_DONE;
            end else if (timeout_c) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               clear_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d == S_CLEAR) clear_d = 1'b1;

      // outputs are registered, so they follow the state being entered
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      req_d  = (state_d == S_REQ_W) || (state_d == S_REQ_D);
      lw_d   = (state_d == S_REQ_W) || (state_d == S_WAIT_W);
      ld_d   = (state_d == S_REQ_D) || (state_d == S_WAIT_D);
      if (state_d == S_REQ_W) begin
         addr_d = wbase_d + ADDR_WIDTH'(req_cnt_d);
      end else if (state_d == S_REQ_D) begin
         addr_d = dbase_d + ADDR_WIDTH'(req_cnt_d);
      end
   end

   // State, counters, latched job parameters and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         req_cnt_q  <= '0;
         wait_cnt_q <= '0;
         num_dim_q  <= '0;
         wbase_q    <= '0;
         dbase_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         req_q      <= 1'b0;
         addr_q     <= '0;
         clear_q    <= 1'b0;
         lw_q       <= 1'b0;
         ld_q       <= 1'b0;
         cstart_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_cnt_q  <= req_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         num_dim_q  <= num_dim_d;
         wbase_q    <= wbase_d;
         dbase_q    <= dbase_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         clear_q    <= clear_d;
         lw_q       <= lw_d;
         ld_q       <= ld_d;
         cstart_q   <= cstart_d;
      end
   end

   assign bus.busy                  = busy_q;
   assign bus.done                  = done_q;
   assign bus.err                   = err_q;
   assign bus.mem_rd_req            = req_q;
   assign bus.mem_rd_addr           = addr_q;
   assign bus.clear_weights_n_data  = clear_q;
   assign bus.loading_weights       = lw_q;
   assign bus.loading_data          = ld_q;
   assign bus.svm_ctrl_part_num_dim = num_dim_q;
   assign bus.compute_start         = cstart_q;

endmodule
